// File: rtl/vga_cell_renderer.sv
// VGA timing generator and cell renderer for the life grid.
// Scans the frame, turns each visible pixel into a board cell address for the
// RAM read port, then colours the returned live bit with cursor and grid
// overlays. Sync and data-enable are delayed so they stay aligned with the
// colour for any RAM read latency. The frame and vblank strobes follow the
// scan position rather than the output pins.
module vga_cell_renderer #(
  parameter int          WIDTH    = 12,
  parameter int          HSIZE    = 800,
  parameter int          HFP      = 856,
  parameter int          HSP      = 976,
  parameter int          HMAX     = 1040,
  parameter int          VSIZE    = 600,
  parameter int          VFP      = 637,
  parameter int          VSP      = 643,
  parameter int          VMAX     = 666,
  parameter bit          HSPP     = 1'b1,
  parameter bit          VSPP     = 1'b1,
  parameter int          CELL_W   = 20,
  parameter int          CELL_H   = 20,
  parameter int          COLS     = HSIZE / CELL_W,
  parameter int          ROWS     = VSIZE / CELL_H,
  parameter int          ADDR_W   = 11,
  parameter int          RD_LAT   = 2,
  parameter logic [23:0] LIVE_RGB = 24'hFFFFFF,
  parameter logic [23:0] DEAD_RGB = 24'h000000,
  parameter logic [23:0] GRID_RGB = 24'h404040
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] cell_addr,
  output logic              cell_addr_vld,
  input  logic              cell_live,
  input  logic              grid_en,
  input  logic              cursor_en,
  input  logic [WIDTH-1:0]  cursor_x,
  input  logic [WIDTH-1:0]  cursor_y,
  output logic              hsync,
  output logic              vsync,
  output logic              data_enable,
  output logic [7:0]        video_red,
  output logic [7:0]        video_green,
  output logic [7:0]        video_blue,
  output logic              frame_start,
  output logic              vblank_start
);

  // Geometry sanity: the cell grid must tile the visible area exactly.
  if (HSIZE % CELL_W != 32'sd0) begin : g_bad_cell_w
    $error("vga_cell_renderer: HSIZE must be a multiple of CELL_W");
  end
  if (VSIZE % CELL_H != 32'sd0) begin : g_bad_cell_h
    $error("vga_cell_renderer: VSIZE must be a multiple of CELL_H");
  end
  if (ADDR_W < $clog2(COLS * ROWS)) begin : g_bad_addr_w
    $error("vga_cell_renderer: ADDR_W too narrow for COLS*ROWS cells");
  end
  if ((RD_LAT < 32'sd0) || (RD_LAT > 32'sd4)) begin : g_bad_rd_lat
    $error("vga_cell_renderer: RD_LAT must be within 0..4");
  end

  localparam logic [WIDTH-1:0]  ZERO_W     = WIDTH'(1'b0);
  localparam logic [WIDTH-1:0]  ONE_W      = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0]  H_LAST     = WIDTH'(HMAX - 32'sd1);
  localparam logic [WIDTH-1:0]  V_LAST     = WIDTH'(VMAX - 32'sd1);
  localparam logic [WIDTH-1:0]  H_VIS      = WIDTH'(HSIZE);
  localparam logic [WIDTH-1:0]  V_VIS      = WIDTH'(VSIZE);
  localparam logic [WIDTH-1:0]  H_VIS_LAST = WIDTH'(HSIZE - 32'sd1);
  localparam logic [WIDTH-1:0]  V_VIS_LAST = WIDTH'(VSIZE - 32'sd1);
  localparam logic [WIDTH-1:0]  CW_LAST    = WIDTH'(CELL_W - 32'sd1);
  localparam logic [WIDTH-1:0]  CH_LAST    = WIDTH'(CELL_H - 32'sd1);
  localparam logic [WIDTH-1:0]  H_FP       = WIDTH'(HFP);
  localparam logic [WIDTH-1:0]  H_SP       = WIDTH'(HSP);
  localparam logic [WIDTH-1:0]  V_FP       = WIDTH'(VFP);
  localparam logic [WIDTH-1:0]  V_SP       = WIDTH'(VSP);
  localparam logic [ADDR_W-1:0] ZERO_A     = ADDR_W'(1'b0);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);

  // Per-pixel attributes that travel alongside the RAM read.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic grid;
    logic cursor;
  } meta_t;

  localparam meta_t META_BLANK = {1'b0, ~HSPP, ~VSPP, 1'b0, 1'b0};

  // Scan state: describes the pixel being scanned in the current cycle.
  logic              run_r;
  logic [WIDTH-1:0]  h_r, v_r;
  logic [WIDTH-1:0]  x_sub_r, y_sub_r;
  logic [WIDTH-1:0]  col_r, row_r;
  logic [ADDR_W-1:0] row_base_r;
  logic [ADDR_W-1:0] cell_addr_r;
  logic              cell_addr_vld_r;
  logic              frame_start_r;
  logic              vblank_start_r;

  // Next scan position.
  logic              h_wrap_s;
  logic [WIDTH-1:0]  h_nx_s, v_nx_s;
  logic [WIDTH-1:0]  x_sub_nx_s, y_sub_nx_s;
  logic [WIDTH-1:0]  col_nx_s, row_nx_s;
  logic [ADDR_W-1:0] row_base_nx_s;
  logic              vld_nx_s;
  logic [ADDR_W-1:0] addr_nx_s;

  // Pipeline and output stage.
  meta_t             meta_now_s;
  meta_t             meta_tap_s;
  logic [23:0]       rgb_nx_s;
  logic [23:0]       rgb_r;
  logic              hsync_r, vsync_r, de_r;

  // Next-state scan counters; the cell mapping is kept by sub-counters so no divide is needed.
  always_comb begin
    h_wrap_s      = (h_r == H_LAST);
    h_nx_s        = h_r;
    v_nx_s        = v_r;
    x_sub_nx_s    = x_sub_r;
    col_nx_s      = col_r;
    y_sub_nx_s    = y_sub_r;
    row_nx_s      = row_r;
    row_base_nx_s = row_base_r;
    if (!run_r) begin
      // First cycle out of reset holds the origin so scanning begins at h=0,v=0.
      h_nx_s        = ZERO_W;
      v_nx_s        = ZERO_W;
      x_sub_nx_s    = ZERO_W;
      col_nx_s      = ZERO_W;
      y_sub_nx_s    = ZERO_W;
      row_nx_s      = ZERO_W;
      row_base_nx_s = ZERO_A;
    end else begin
      if (h_wrap_s) begin
        h_nx_s = ZERO_W;
        if (v_r == V_LAST) begin
          v_nx_s = ZERO_W;
        end else begin
          v_nx_s = v_r + ONE_W;
        end
      end else begin
        h_nx_s = h_r + ONE_W;
        v_nx_s = v_r;
      end

      // Column tracking across the visible part of the line; cleared from h=HSIZE on.
      if (h_r < H_VIS_LAST) begin
        if (x_sub_r == CW_LAST) begin
          x_sub_nx_s = ZERO_W;
          col_nx_s   = col_r + ONE_W;
        end else begin
          x_sub_nx_s = x_sub_r + ONE_W;
          col_nx_s   = col_r;
        end
      end else begin
        x_sub_nx_s = ZERO_W;
        col_nx_s   = ZERO_W;
      end

      // Row tracking advances once per line; cleared once the visible lines are done.
      if (h_wrap_s) begin
        if (v_r < V_VIS_LAST) begin
          if (y_sub_r == CH_LAST) begin
            y_sub_nx_s    = ZERO_W;
            row_nx_s      = row_r + ONE_W;
            row_base_nx_s = row_base_r + COLS_A;
          end else begin
            y_sub_nx_s    = y_sub_r + ONE_W;
            row_nx_s      = row_r;
            row_base_nx_s = row_base_r;
          end
        end else begin
          y_sub_nx_s    = ZERO_W;
          row_nx_s      = ZERO_W;
          row_base_nx_s = ZERO_A;
        end
      end else begin
        y_sub_nx_s    = y_sub_r;
        row_nx_s      = row_r;
        row_base_nx_s = row_base_r;
      end
    end

    vld_nx_s = (h_nx_s < H_VIS) && (v_nx_s < V_VIS);
    if (vld_nx_s) begin
      addr_nx_s = row_base_nx_s + ADDR_W'(col_nx_s);
    end else begin
      addr_nx_s = ZERO_A;
    end
  end

  // Scan state register; address and strobes are registered together with h/v.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_r           <= 1'b0;
      h_r             <= ZERO_W;
      v_r             <= ZERO_W;
      x_sub_r         <= ZERO_W;
      col_r           <= ZERO_W;
      y_sub_r         <= ZERO_W;
      row_r           <= ZERO_W;
      row_base_r      <= ZERO_A;
      cell_addr_r     <= ZERO_A;
      cell_addr_vld_r <= 1'b0;
      frame_start_r   <= 1'b0;
      vblank_start_r  <= 1'b0;
    end else begin
      run_r           <= 1'b1;
      h_r             <= h_nx_s;
      v_r             <= v_nx_s;
      x_sub_r         <= x_sub_nx_s;
      col_r           <= col_nx_s;
      y_sub_r         <= y_sub_nx_s;
      row_r           <= row_nx_s;
      row_base_r      <= row_base_nx_s;
      cell_addr_r     <= addr_nx_s;
      cell_addr_vld_r <= vld_nx_s;
      frame_start_r   <= (h_nx_s == ZERO_W) && (v_nx_s == ZERO_W);
      vblank_start_r  <= (h_nx_s == ZERO_W) && (v_nx_s == V_VIS);
    end
  end

  // Attributes of the pixel being scanned, with overlay inputs sampled now.
  always_comb begin
    meta_now_s        = META_BLANK;
    meta_now_s.de     = cell_addr_vld_r;
    meta_now_s.hs     = ((h_r >= H_FP) && (h_r < H_SP)) ? HSPP : ~HSPP;
    meta_now_s.vs     = ((v_r >= V_FP) && (v_r < V_SP)) ? VSPP : ~VSPP;
    meta_now_s.grid   = grid_en && ((x_sub_r == ZERO_W) || (y_sub_r == ZERO_W));
    meta_now_s.cursor = cursor_en && cell_addr_vld_r &&
                        (col_r == cursor_x) && (row_r == cursor_y);
  end

  if (RD_LAT == 0) begin : g_no_delay
    assign meta_tap_s = meta_now_s;
  end else begin : g_delay
    meta_t dl_r [RD_LAT];

    // Delay line matching the RAM read latency; flushes to blank on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < RD_LAT; k++) begin
          dl_r[k] <= META_BLANK;
        end
      end else begin
        dl_r[0] <= meta_now_s;
        for (int k = 1; k < RD_LAT; k++) begin
          dl_r[k] <= dl_r[k-1];
        end
      end
    end

    assign meta_tap_s = dl_r[RD_LAT-1];
  end

  // Colour selection: cursor above grid above the live/dead fill, black when blanked.
  always_comb begin
    rgb_nx_s = 24'h000000;
    if (!meta_tap_s.de) begin
      rgb_nx_s = 24'h000000;
    end else if (meta_tap_s.cursor) begin
      rgb_nx_s = cell_live ? 24'hFF0000 : 24'h0000FF;
    end else if (meta_tap_s.grid) begin
      rgb_nx_s = GRID_RGB;
    end else begin
      rgb_nx_s = cell_live ? LIVE_RGB : DEAD_RGB;
    end
  end

  // Output stage: colour, sync and enable all leave on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_r   <= 24'h000000;
      hsync_r <= ~HSPP;
      vsync_r <= ~VSPP;
      de_r    <= 1'b0;
    end else begin
      rgb_r   <= rgb_nx_s;
      hsync_r <= meta_tap_s.hs;
      vsync_r <= meta_tap_s.vs;
      de_r    <= meta_tap_s.de;
    end
  end

  assign cell_addr     = cell_addr_r;
  assign cell_addr_vld = cell_addr_vld_r;
  assign frame_start   = frame_start_r;
  assign vblank_start  = vblank_start_r;
  assign hsync         = hsync_r;
  assign vsync         = vsync_r;
  assign data_enable   = de_r;
  assign video_red     = rgb_r[23:16];
  assign video_green   = rgb_r[15:8];
  assign video_blue    = rgb_r[7:0];

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Self-checking bench for vga_cell_renderer.
// Four instances share clock, reset and overlay inputs: three small-geometry
// builds with RD_LAT 0, 2 and 4 (negative hsync) and one default 800x600
// build. Each has its own board-RAM model with the matching read latency.
// Expected scan and pin values come from the frame arithmetic (h = n mod HMAX,
// col = h / CELL_W, ...) applied to the cycle count since reset.
module tb_vga_cell_renderer;

  localparam int TOTAL = 31000;
  localparam int MID   = 25000;

  logic        clk = 1'b0;
  logic        rst;
  logic        grid_en;
  logic        cursor_en;
  logic [11:0] cursor_x;
  logic [11:0] cursor_y;

  bit mem [2048];
  bit hist_g  [16];
  bit hist_ce [16];
  int hist_cx [16];
  int hist_cy [16];

  int cyc;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit BIG   = (g == 3);
    localparam int HSZ   = BIG ? 800  : 40;
    localparam int HFP_  = BIG ? 856  : 44;
    localparam int HSP_  = BIG ? 976  : 50;
    localparam int HMX   = BIG ? 1040 : 56;
    localparam int VSZ   = BIG ? 600  : 24;
    localparam int VFP_  = BIG ? 637  : 26;
    localparam int VSP_  = BIG ? 643  : 28;
    localparam int VMX   = BIG ? 666  : 30;
    localparam int CW    = BIG ? 20   : 8;
    localparam int CH    = BIG ? 20   : 6;
    localparam int NCOL  = HSZ / CW;
    localparam int AW    = BIG ? 11   : 5;
    localparam int LAT   = BIG ? 2    : 2 * g;
    localparam bit HP    = BIG ? 1'b1 : 1'b0;
    localparam bit VP    = 1'b1;

    logic [AW-1:0] addr_w;
    logic          vld_w, live_w, hs_w, vs_w, de_w, fs_w, vb_w;
    logic [7:0]    r_w, g_w, b_w;

    vga_cell_renderer #(
      .WIDTH(12), .HSIZE(HSZ), .HFP(HFP_), .HSP(HSP_), .HMAX(HMX),
      .VSIZE(VSZ), .VFP(VFP_), .VSP(VSP_), .VMAX(VMX),
      .HSPP(HP), .VSPP(VP), .CELL_W(CW), .CELL_H(CH),
      .ADDR_W(AW), .RD_LAT(LAT)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cell_addr(addr_w), .cell_addr_vld(vld_w), .cell_live(live_w),
      .grid_en(grid_en), .cursor_en(cursor_en),
      .cursor_x(cursor_x), .cursor_y(cursor_y),
      .hsync(hs_w), .vsync(vs_w), .data_enable(de_w),
      .video_red(r_w), .video_green(g_w), .video_blue(b_w),
      .frame_start(fs_w), .vblank_start(vb_w)
    );

    // RAM model plus per-cycle comparison against the frame arithmetic.
    initial begin
      int ah [8];
      int n, h, v, p, ph, pv, col, row, idx;
      bit vis, pvis, live;
      logic [23:0] rgb;
      logic [63:0] exp_scan, exp_pin;
      string tag_scan, tag_pin;
      tag_scan = $sformatf("scan_i%0d", g);
      tag_pin  = $sformatf("pins_i%0d", g);
      live_w = 1'b0;
      for (int k = 0; k < 8; k++) ah[k] = 0;
      forever begin
        @(negedge clk);
        for (int k = 7; k > 0; k--) ah[k] = ah[k-1];
        ah[0]  = int'(addr_w);
        live_w = mem[ah[LAT]];
        n = cyc;
        if (n >= -1) begin
          exp_pin = {37'd0, 1'b0, !HP, !VP, 24'h000000};
          if (n < 0) begin
            exp_scan = 64'd0;
          end else begin
            h   = n % HMX;
            v   = (n / HMX) % VMX;
            vis = (h < HSZ) && (v < VSZ);
            exp_scan = {45'd0, vis, (h == 0 && v == 0), (h == 0 && v == VSZ),
                        vis ? 16'((v / CH) * NCOL + h / CW) : 16'd0};
            if (n >= LAT + 1) begin
              p    = n - LAT - 1;
              ph   = p % HMX;
              pv   = (p / HMX) % VMX;
              pvis = (ph < HSZ) && (pv < VSZ);
              col  = ph / CW;
              row  = pv / CH;
              idx  = p % 16;
              live = pvis ? mem[row * NCOL + col] : 1'b0;
              rgb  = 24'h000000;
              if (pvis) begin
                if (hist_ce[idx] && col == hist_cx[idx] && row == hist_cy[idx])
                  rgb = live ? 24'hFF0000 : 24'h0000FF;
                else if (hist_g[idx] && ((ph % CW) == 0 || (pv % CH) == 0))
                  rgb = 24'h404040;
                else
                  rgb = live ? 24'hFFFFFF : 24'h000000;
              end
              exp_pin = {37'd0, pvis,
                         (ph >= HFP_ && ph < HSP_) ? HP : !HP,
                         (pv >= VFP_ && pv < VSP_) ? VP : !VP, rgb};
            end
          end
          check_eq(tag_scan, {45'd0, vld_w, fs_w, vb_w, 16'(addr_w)}, exp_scan);
          check_eq(tag_pin, {37'd0, de_w, hs_w, vs_w, r_w, g_w, b_w}, exp_pin);
        end
      end
    end
  end

  // Reset, overlay stimulus and board contents; cyc counts scan cycles since reset release.
  initial begin
    rst       = 1'b1;
    grid_en   = 1'b0;
    cursor_en = 1'b0;
    cursor_x  = 12'd0;
    cursor_y  = 12'd0;
    cyc       = -2;
    for (int k = 0; k < 2048; k++) mem[k] = 1'($urandom_range(0, 1));
    for (int i = 0; i < TOTAL; i++) begin
      @(posedge clk);
      #1;
      if (rst) cyc = -1;
      else     cyc = cyc + 1;
      rst = (i < 2) || (i >= MID && i < MID + 2);
      if (cyc == -1 && i > MID) begin
        for (int k = 0; k < 2048; k++) mem[k] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 7) == 0) begin
        grid_en   = 1'($urandom_range(0, 1));
        cursor_en = ($urandom_range(0, 3) != 0);
        cursor_x  = 12'($urandom_range(0, 5));
        cursor_y  = 12'($urandom_range(0, 4));
      end
      if (cyc >= 0) begin
        hist_g[cyc % 16]  = grid_en;
        hist_ce[cyc % 16] = cursor_en;
        hist_cx[cyc % 16] = int'(cursor_x);
        hist_cy[cyc % 16] = int'(cursor_y);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
